// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line in, received word and status out, between the line side and the receive controller
interface uart_rx_ctrl_if #(parameter int DATA_BITS = 8);
   logic rx;
   logic fall;
   logic [DATA_BITS-1:0] data;
   logic data_valid;
   logic frame_err;
   logic busy;
   modport master(output rx, fall, input data, data_valid, frame_err, busy);
   modport slave(input rx, fall, output data, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start/data/stop deserializer with mid-bit sampling, LSB-first, one-cycle valid/error pulses
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS = 8
) (
   input logic clk,
   input logic rst,
   uart_rx_ctrl_if.slave bus
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_params
      $error("uart_rx_ctrl: CLKS_PER_BIT must be >= 4 and DATA_BITS in 5..9");
   end
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [DATA_BITS-1:0] shreg, data_q;
   logic valid_q, err_q;
   logic tick, last_bit, shift, good, bad, cnt_clr;
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.fall ? START : IDLE;
         START:   state_nx = tick ? (bus.rx ? IDLE : DATA) : START;
         DATA:    state_nx = (tick && last_bit) ? STOP : DATA;
         STOP:    state_nx = tick ? IDLE : STOP;
         default: state_nx = IDLE;
      endcase
   end
   // START samples at half a bit so every later sample lands mid-bit
   always_comb begin
      tick = (state == START) ? (cnt == HALF_END) : ((state == DATA || state == STOP) && cnt == BIT_END);
      last_bit = idx == LAST_IDX;
      shift = state == DATA && tick;
      good = state == STOP && tick && bus.rx;
      bad = state == STOP && tick && !bus.rx;
      cnt_clr = state == IDLE || tick;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         shreg <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + 1'b1;
         idx <= (state == START) ? '0 : (shift ? idx + 1'b1 : idx);
         shreg <= shift ? {bus.rx, shreg[DATA_BITS-1:1]} : shreg;
         data_q <= good ? shreg : data_q;
         valid_q <= good;
         err_q <= bad;
      end
   end
   assign bus.data = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err = err_q;
   assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: plays per-cycle line plans into the receiver and checks every cycle against a frame-timing model
module tb_uart_rx_ctrl;
   localparam int CPB = 8;
   localparam int DB = 8;
   localparam int HALF = CPB / 2;
   localparam int MAXN = 1500;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   uart_rx_ctrl_if #(.DATA_BITS(DB)) bus();
   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
   bit rx_l[MAXN], fall_l[MAXN], rst_l[MAXN];
   logic obs_v[MAXN], obs_e[MAXN], obs_b[MAXN];
   logic [DB-1:0] obs_d[MAXN];
   logic exp_v[MAXN+1], exp_e[MAXN+1], exp_b[MAXN+1];
   logic [DB-1:0] exp_d[MAXN+1];
   logic [DB-1:0] model_data = '0;
   int n = 0;
   int checks = 0;
   int failures = 0;
   task automatic put_bit(input bit v, input int len);
      for (int i = 0; i < len; i++) begin
         rx_l[n] = v;
         fall_l[n] = (n > 0 ? rx_l[n-1] : 1'b1) & ~v;
         rst_l[n] = 1'b0;
         n++;
      end
   endtask
   task automatic put_frame(input logic [DB-1:0] d, input bit stop_ok, output int t);
      t = n;
      put_bit(1'b0, CPB);
      for (int k = 0; k < DB; k++) put_bit(d[k], CPB);
      put_bit(stop_ok, CPB);
   endtask
   // Frame-level reference: a start at T samples at T+HALF, bit k at T+HALF+(k+1)*CPB, stop after the last bit
   task automatic model_plan();
      bit active = 1'b0;
      int t0 = 0;
      int rel, k;
      logic [DB-1:0] word = '0;
      exp_v[0] = 1'b0;
      exp_e[0] = 1'b0;
      exp_b[0] = 1'b0;
      exp_d[0] = model_data;
      for (int c = 0; c < n; c++) begin
         exp_v[c+1] = 1'b0;
         exp_e[c+1] = 1'b0;
         if (rst_l[c]) begin
            active = 1'b0;
            model_data = '0;
         end else if (!active) begin
            if (fall_l[c]) begin
               active = 1'b1;
               t0 = c;
            end
         end else begin
            rel = c - t0;
            if (rel == HALF) begin
               if (rx_l[c]) active = 1'b0;
            end else if (rel > HALF && (rel - HALF) % CPB == 0) begin
               k = (rel - HALF) / CPB - 1;
               if (k < DB) word[k] = rx_l[c];
               else begin
                  active = 1'b0;
                  if (rx_l[c]) begin
                     model_data = word;
                     exp_v[c+1] = 1'b1;
                  end else exp_e[c+1] = 1'b1;
               end
            end
         end
         exp_b[c+1] = active;
         exp_d[c+1] = model_data;
      end
   endtask
   task automatic run_plan();
      model_plan();
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         obs_v[c] = bus.data_valid;
         obs_e[c] = bus.frame_err;
         obs_b[c] = bus.busy;
         obs_d[c] = bus.data;
         bus.rx = rx_l[c];
         bus.fall = fall_l[c];
         rst = rst_l[c];
      end
   endtask
   task automatic test_reset();
      n = 0;
      put_bit(1'b1, 8);
      for (int i = 0; i < 3; i++) rst_l[i] = 1'b1;
      run_plan();
      for (int c = 1; c < 8; c++) begin
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== 11'b0) begin
            failures++;
            $display("FAIL reset_state cyc=%0d got v=%b e=%b busy=%b data=%h want all 0", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c]);
         end
      end
      for (int c = 1; c < n; c++) begin
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL reset_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
   endtask
   task automatic test_single_frame();
      int t, nv, ne;
      n = 0;
      put_bit(1'b1, 10);
      put_frame(8'h55, 1'b1, t);
      put_bit(1'b1, 100);
      run_plan();
      nv = 0;
      ne = 0;
      for (int c = 1; c < n; c++) begin
         nv += int'(obs_v[c] === 1'b1);
         ne += int'(obs_e[c] !== 1'b0);
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL single_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
      checks++;
      if (obs_v[t+77] !== 1'b1 || obs_d[t+77] !== 8'h55 || nv != 1 || ne != 0) begin
         failures++;
         $display("FAIL single_0x55 got v@T+77=%b data=%h pulses=%0d errs=%0d want 1 55 1 0", obs_v[t+77], obs_d[t+77], nv, ne);
      end
      checks++;
      if (obs_b[t] !== 1'b0 || obs_b[t+1] !== 1'b1 || obs_b[t+76] !== 1'b1 || obs_b[t+77] !== 1'b0) begin
         failures++;
         $display("FAIL single_busy got T=%b T+1=%b S=%b S+1=%b want 0110", obs_b[t], obs_b[t+1], obs_b[t+76], obs_b[t+77]);
      end
   endtask
   task automatic test_back_to_back();
      int t1, t2;
      n = 0;
      put_bit(1'b1, 10);
      put_frame(8'hA3, 1'b1, t1);
      put_frame(8'h00, 1'b1, t2);
      put_bit(1'b1, 100);
      run_plan();
      for (int c = 1; c < n; c++) begin
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL b2b_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
      checks++;
      if (obs_v[t1+77] !== 1'b1 || obs_d[t1+77] !== 8'hA3 || obs_v[t2+77] !== 1'b1 || obs_d[t2+77] !== 8'h00 || t2 - t1 != 80) begin
         failures++;
         $display("FAIL b2b_words got v1=%b d1=%h v2=%b d2=%h want 1 a3 1 00", obs_v[t1+77], obs_d[t1+77], obs_v[t2+77], obs_d[t2+77]);
      end
   endtask
   task automatic test_glitch();
      int t, t2, nv;
      n = 0;
      put_bit(1'b1, 10);
      t = n;
      put_bit(1'b0, 2);
      put_bit(1'b1, 20);
      put_frame(8'h3C, 1'b1, t2);
      put_bit(1'b1, 100);
      run_plan();
      nv = 0;
      for (int c = 1; c < n; c++) begin
         if (c < t2) nv += int'(obs_v[c] !== 1'b0 || obs_e[c] !== 1'b0);
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL glitch_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
      checks++;
      if (obs_b[t+4] !== 1'b1 || obs_b[t+5] !== 1'b0 || nv != 0) begin
         failures++;
         $display("FAIL glitch_drop got busy T+4=%b T+5=%b pulses=%0d want 1 0 0", obs_b[t+4], obs_b[t+5], nv);
      end
      checks++;
      if (obs_v[t2+77] !== 1'b1 || obs_d[t2+77] !== 8'h3C) begin
         failures++;
         $display("FAIL glitch_next got v=%b data=%h want 1 3c", obs_v[t2+77], obs_d[t2+77]);
      end
   endtask
   task automatic test_frame_err();
      int t1, t2;
      n = 0;
      put_bit(1'b1, 10);
      put_frame(8'h12, 1'b1, t1);
      put_bit(1'b1, 5);
      put_frame(8'hFF, 1'b0, t2);
      put_bit(1'b1, 100);
      run_plan();
      for (int c = 1; c < n; c++) begin
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL ferr_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
      checks++;
      if (obs_e[t2+77] !== 1'b1 || obs_v[t2+77] !== 1'b0 || obs_d[t2+77] !== 8'h12 || obs_e[t2+78] !== 1'b0) begin
         failures++;
         $display("FAIL ferr_pulse got e=%b v=%b data=%h e_next=%b want 1 0 12 0", obs_e[t2+77], obs_v[t2+77], obs_d[t2+77], obs_e[t2+78]);
      end
   endtask
   task automatic test_mid_reset();
      int t, t2, fend;
      n = 0;
      put_bit(1'b1, 10);
      put_frame(8'($urandom), 1'b1, t);
      fend = n;
      rst_l[t+35] = 1'b1;
      for (int i = t + 36; i < fend; i++) begin
         rx_l[i] = 1'b1;
         fall_l[i] = 1'b0;
      end
      put_bit(1'b1, 10);
      put_frame(8'h3C, 1'b1, t2);
      put_bit(1'b1, 100);
      run_plan();
      for (int c = 1; c < n; c++) begin
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL mreset_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
      checks++;
      if ({obs_v[t+36], obs_e[t+36], obs_b[t+36], obs_d[t+36]} !== 11'b0 || obs_b[t+35] !== 1'b1) begin
         failures++;
         $display("FAIL mreset_clear got v=%b e=%b busy=%b data=%h want all 0", obs_v[t+36], obs_e[t+36], obs_b[t+36], obs_d[t+36]);
      end
      checks++;
      if (obs_v[t2+77] !== 1'b1 || obs_d[t2+77] !== 8'h3C) begin
         failures++;
         $display("FAIL mreset_next got v=%b data=%h want 1 3c", obs_v[t2+77], obs_d[t2+77]);
      end
   endtask
   task automatic test_extra_fall();
      int t, nv;
      n = 0;
      put_bit(1'b1, 10);
      put_frame(8'h81, 1'b1, t);
      put_bit(1'b1, 100);
      fall_l[t+30] = 1'b1;
      fall_l[t+74] = 1'b1;
      run_plan();
      nv = 0;
      for (int c = 1; c < n; c++) begin
         nv += int'(obs_v[c] === 1'b1);
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL xfall_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
      checks++;
      if (obs_v[t+77] !== 1'b1 || obs_d[t+77] !== 8'h81 || nv != 1) begin
         failures++;
         $display("FAIL xfall_word got v=%b data=%h pulses=%0d want 1 81 1", obs_v[t+77], obs_d[t+77], nv);
      end
   endtask
   task automatic test_random();
      int t, nok, nv, ne;
      bit ok;
      n = 0;
      nok = 0;
      put_bit(1'b1, 10);
      for (int f = 0; f < 5; f++) begin
         ok = $urandom_range(0, 3) != 0;
         nok += int'(ok);
         put_frame(8'($urandom), ok, t);
         put_bit(1'b1, ok ? $urandom_range(0, 3) : $urandom_range(1, 3));
      end
      put_bit(1'b1, 100);
      run_plan();
      nv = 0;
      ne = 0;
      for (int c = 1; c < n; c++) begin
         nv += int'(obs_v[c] === 1'b1);
         ne += int'(obs_e[c] === 1'b1);
         checks++;
         if ({obs_v[c], obs_e[c], obs_b[c], obs_d[c]} !== {exp_v[c], exp_e[c], exp_b[c], exp_d[c]}) begin
            failures++;
            $display("FAIL random_trace cyc=%0d got v/e/b/d=%b%b%b/%h want %b%b%b/%h", c, obs_v[c], obs_e[c], obs_b[c], obs_d[c], exp_v[c], exp_e[c], exp_b[c], exp_d[c]);
         end
      end
      checks++;
      if (nv != nok || ne != 5 - nok) begin
         failures++;
         $display("FAIL random_counts got valid=%0d err=%0d want %0d %0d", nv, ne, nok, 5 - nok);
      end
   endtask
   initial begin
      bus.rx = 1'b1;
      bus.fall = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_mid_reset();
      test_extra_fall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that turns a synchronized serial line into parallel bytes. It sits directly downstream of the edge detector and uses that stage's `fall` strobe as the start-bit trigger. It times mid-bit sampling with a baud counter and deserializes LSB-first data. It emits a one-cycle `data_valid` pulse per good frame, or a `frame_err` pulse when the stop bit is bad. Frame format is fixed 8N1-style: 1 start bit, `DATA_BITS` data bits, 1 stop bit, no parity.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200); must be >= 4.
- `DATA_BITS`, 8, data bits per frame; range 5..9.
- `clk`  input  1  clock, posedge active.
- `rst`  input  1  reset, synchronous, active-high.
- `rx`  input  1  serial line, already synchronized to `clk`; idle high.
- `fall`  input  1  start strobe from edge detector; high in the cycle `rx` is first seen low.
- `data`  output  DATA_BITS  last good received word; holds its value until the next good frame.
- `data_valid`  output  1  one-cycle pulse; `data` is new in this cycle.
- `frame_err`  output  1  one-cycle pulse; stop bit was sampled as 0.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- Derived constants:
  - `HALF = CLKS_PER_BIT/2`, integer division.
  - Bit counter width is `$clog2(CLKS_PER_BIT)`.
  - Bit index width is `$clog2(DATA_BITS+1)`.
- States are IDLE, START, DATA and STOP.
- IDLE: when `fall`=1, go to START and clear the counter. `rx` is otherwise ignored.
- START: the counter increments each cycle. At `cnt==HALF-1`, sample `rx`:
  - `rx`=0: go to DATA; clear the counter and the bit index.
  - `rx`=1: treat as a glitch and return to IDLE; no output pulse.
- DATA: at `cnt==CLKS_PER_BIT-1`, sample `rx`, clear the counter and increment the bit index.
  - Shift register shifts right; the sample enters at the MSB, so the word is LSB-first.
  - After the `DATA_BITS`-th sample, go to STOP.
- STOP: at `cnt==CLKS_PER_BIT-1`, sample `rx`, then go to IDLE:
  - `rx`=1: load `data` from the shift register and pulse `data_valid`.
  - `rx`=0: pulse `frame_err`; `data` is unchanged.
- `fall` is ignored in every state except IDLE.
- `data_valid` and `frame_err` are never high together.
- Reset, including mid-frame: next state is IDLE; counter, bit index, shift register, `data`, `data_valid` and `frame_err` go to 0.
- Reset value of every output is 0, with `busy`=0.

## Timing
- Reference point T is the cycle in which `fall`=1 while in IDLE.
- START is entered at T+1 with `cnt`=0.
- Start-bit sample is at T+HALF.
- Data bit k (k=0..DATA_BITS-1) is sampled at T+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit is sampled at S = T+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
- Cycle S+1:
  - `data_valid` or `frame_err` is high for exactly one cycle.
  - State is IDLE and `busy`=0.
  - A `fall` in this cycle is accepted as a new frame.
- `busy` is 1 from T+1 through S inclusive.
- Glitch case: `busy` is 1 for cycles T+1..T+HALF and 0 from T+HALF+1.
- Latency from start-bit edge to `data_valid` is HALF+(DATA_BITS+1)·CLKS_PER_BIT+1 cycles.
- Back-to-back frames, where the start edge immediately follows the stop bit, must be received without loss.

## Test plan
All scenarios use `CLKS_PER_BIT`=8 and `DATA_BITS`=8, so the frame period is 80 cycles and `data_valid` comes at T+77.
- Frame 0x55 sent with correct timing -> `data_valid` high only at T+77, `data`=0x55, `frame_err` never high.
- Frames 0xA3 then 0x00 sent back-to-back -> two `data_valid` pulses 80 cycles apart, with `data`=0xA3 then 0x00, no errors.
- `rx` low for 2 cycles, then high -> `busy` drops at T+5, no `data_valid`, no `frame_err`; a following 0x3C frame is received correctly.
- Frame 0xFF with stop bit driven 0, after a prior good 0x12 -> `frame_err` pulse at T+77, `data` stays 0x12, `data_valid` stays 0.
- `rst` asserted for 1 cycle during DATA bit 3 -> next cycle all outputs 0 and `busy`=0; the next 0x3C frame yields `data`=0x3C.
- Extra `fall` pulses forced during DATA and STOP of frame 0x81 -> ignored; single `data_valid` at T+77 with `data`=0x81.
